// File: rtl/keypad_entry_buffer_if.sv
// Key-event and display/entry signals between keypad_entry_buffer and its neighbours.
// The master drives key events; the slave (the entry buffer) drives the display and entry results.
interface keypad_entry_buffer_if #(
  parameter int NUM_DIGITS = 3
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic [3:0]              key_code;
  logic                    key_valid;
  logic [3:0]              digit_val;
  logic [NUM_DIGITS-1:0]   an;
  logic                    blank;
  logic [CNT_W-1:0]        digit_count;
  logic [4*NUM_DIGITS-1:0] entry_value;
  logic                    entry_valid;

  modport master (
    output key_code, key_valid,
    input  digit_val, an, blank, digit_count, entry_value, entry_valid
  );

  modport slave (
    input  key_code, key_valid,
    output digit_val, an, blank, digit_count, entry_value, entry_valid
  );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Assembles keypad digits into a BCD entry, commits it on '#', and scans the digits onto a 7-seg bus.
// Optional macro KEY_ENTRY_BLANK_EN blanks the positions that hold no entered digit.
module keypad_entry_buffer #(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 27000
) (
  input  logic               clk,
  input  logic               n_reset,
  keypad_entry_buffer_if.slave bus
);

  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BUF_W  = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BUF_W-1:0]    buffer_q, buffer_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BUF_W-1:0]    entry_value_q, entry_value_d;
  logic                entry_valid_q, entry_valid_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]          digit_val_q, digit_val_d;
  logic                blank_q, blank_d;

  logic is_digit_s, is_star_s, is_hash_s;

  assign is_digit_s = (bus.key_code <= 4'd9);
  assign is_star_s  = (bus.key_code == 4'hE);
  assign is_hash_s  = (bus.key_code == 4'hF);

  // Entry FSM: digit shifting, clear, and commit of the buffer.
  always_comb begin
    state_d       = state_q;
    buffer_d      = buffer_q;
    count_d       = count_q;
    entry_value_d = entry_value_q;
    entry_valid_d = 1'b0;
    if (bus.key_valid) begin
      if (is_star_s) begin
        buffer_d = '0;
        count_d  = '0;
        state_d  = EMPTY;
      end else if (is_digit_s) begin
        case (state_q)
          EMPTY, ENTRY: begin
            buffer_d = {buffer_q[BUF_W-5:0], bus.key_code};
            count_d  = count_q + CNT_W'(1);
            state_d  = (count_q == CNT_W'(NUM_DIGITS - 1)) ? FULL : ENTRY;
          end
          FULL: begin
            state_d = FULL;
          end
          DONE: begin
            buffer_d = {{(BUF_W-4){1'b0}}, bus.key_code};
            count_d  = CNT_W'(1);
            state_d  = ENTRY;
          end
          default: begin
            state_d = EMPTY;
          end
        endcase
      end else if (is_hash_s) begin
        case (state_q)
          ENTRY, FULL: begin
            entry_value_d = buffer_q;
            entry_valid_d = 1'b1;
            state_d       = DONE;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Display scan; outputs are derived from next-state so the registers track the current buffer.
  always_comb begin
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      idx_d      = idx_q;
    end
    an_d        = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d);
    digit_val_d = buffer_d[{idx_d, 2'b00} +: 4];
`ifdef KEY_ENTRY_BLANK_EN
    blank_d = (CNT_W'(idx_d) >= count_d) && !((idx_d == '0) && (count_d == '0));
`else
    blank_d = 1'b0;
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q       <= EMPTY;
      buffer_q      <= '0;
      count_q       <= '0;
      entry_value_q <= '0;
      entry_valid_q <= 1'b0;
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      an_q          <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      digit_val_q   <= 4'd0;
      blank_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      buffer_q      <= buffer_d;
      count_q       <= count_d;
      entry_value_q <= entry_value_d;
      entry_valid_q <= entry_valid_d;
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      an_q          <= an_d;
      digit_val_q   <= digit_val_d;
      blank_q       <= blank_d;
    end
  end

  assign bus.digit_val   = digit_val_q;
  assign bus.an          = an_q;
  assign bus.blank       = blank_q;
  assign bus.digit_count = count_q;
  assign bus.entry_value = entry_value_q;
  assign bus.entry_valid = entry_valid_q;

endmodule
